// File: rtl/lcd_text_refresh_driver_pkg.sv
// lcd_pkg: shared LCD command bytes, FSM states and helpers for the text refresh driver.
// Build option LCD_CURSOR_BLINK_EN selects the cursor-on/blink DISP_ON command.
package lcd_pkg;
    localparam int LCD_COLS = 16;
    localparam logic [7:0] LCD_CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] LCD_CMD_DISP_BLINK = 8'h0F;
    localparam logic [7:0] LCD_CMD_ENTRY      = 8'h06;
    localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_CMD_LINE1      = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2      = 8'hC0;
`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_CMD = LCD_CMD_DISP_BLINK;
`else
    localparam logic [7:0] DISP_CMD = LCD_CMD_DISP_ON;
`endif

    typedef enum logic [3:0] {
        PWR_WAIT, FUNC_SET, DISP_ON, ENTRY, CLEAR, ADDR1, LINE1, ADDR2, LINE2
    } lcd_state_e;

    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} wc_phase_e;

    function automatic logic is_data(lcd_state_e s);
        return s == LINE1 || s == LINE2;
    endfunction

    function automatic logic [7:0] cmd_byte(lcd_state_e s);
        return s == FUNC_SET ? LCD_CMD_FUNC_SET :
               s == DISP_ON  ? DISP_CMD :
               s == ENTRY    ? LCD_CMD_ENTRY :
               s == CLEAR    ? LCD_CMD_CLEAR :
               s == ADDR1    ? LCD_CMD_LINE1 :
               s == ADDR2    ? LCD_CMD_LINE2 : 8'h00;
    endfunction
endpackage

// File: rtl/lcd_text_refresh_driver_if.sv
// lcd_text_refresh_driver_if: character-generator lookup and LCD pin bundle.
interface lcd_text_refresh_driver_if;
    logic [4:0] index;
    logic [7:0] char_in;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       init_done;
    logic       frame_done;

    modport master (
        output index, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done,
        input  char_in
    );

    modport slave (
        input  index, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done,
        output char_in
    );
endinterface

// File: rtl/lcd_write_cycle.sv
// lcd_write_cycle: tick-paced SETUP/STROBE/HOLD sequencer for one LCD byte write.
module lcd_write_cycle
    import lcd_pkg::*;
#(
    parameter int WW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic          rs,
    input  logic [7:0]    data_byte,
    input  logic [WW-1:0] wait_ticks,
    output logic          lcd_e,
    output logic          lcd_rs,
    output logic [7:0]    lcd_data,
    output logic          done
);
    wc_phase_e     phase_q, phase_d;
    logic [WW-1:0] cnt_q, cnt_d, wait_q, wait_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d, e_q, e_d, late_q, late_d;

    assign done     = phase_q == PH_HOLD && tick && cnt_q == wait_q - 1'b1;
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        data_d  = data_q;
        rs_d    = rs_q;
        late_d  = phase_q == PH_SETUP;
        // char_in trails index by one clk: re-sample data bytes once SETUP is past its first clk
        if (phase_q == PH_SETUP && late_q && rs_q) data_d = data_byte;
        if (tick) begin
            phase_d = phase_q == PH_SETUP ? PH_STROBE : phase_q == PH_STROBE ? PH_HOLD : phase_q;
            cnt_d   = phase_q == PH_HOLD ? cnt_q + 1'b1 : '0;
        end
        if (done) phase_d = PH_IDLE;
        if (start) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            wait_d  = wait_ticks;
            data_d  = data_byte;
            rs_d    = rs;
        end
        e_d = phase_d == PH_STROBE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            late_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            late_q  <= late_d;
        end
    end
endmodule

// File: rtl/lcd_text_refresh_driver.sv
// lcd_text_refresh_driver: HD44780 16x2 init sequencer and endless two-line refresh.
// Build option LCD_CURSOR_BLINK_EN switches DISP_ON to cursor-on/blink (see lcd_pkg).
module lcd_text_refresh_driver
    import lcd_pkg::*;
#(
    parameter int TICK_DIV       = 50,
    parameter int PWR_WAIT_TICKS = 15000,
    parameter int CMD_WAIT_TICKS = 40,
    parameter int CLR_WAIT_TICKS = 1640
) (
    input logic                        clk,
    input logic                        rst,
    lcd_text_refresh_driver_if.master  bus
);
    localparam int WMAX = PWR_WAIT_TICKS > CLR_WAIT_TICKS ? PWR_WAIT_TICKS : CLR_WAIT_TICKS;
    localparam int WW   = $clog2(WMAX + 1);
    localparam int TW   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    lcd_state_e    state_q, state_d;
    logic [TW-1:0] pre_q, pre_d;
    logic [WW-1:0] pwr_q, pwr_d;
    logic [3:0]    slot_q, slot_d;
    logic [4:0]    index_q, index_d;
    logic          init_q, init_d, frame_q, frame_d;
    logic          tick, start, done, last, wc_rs;
    logic [7:0]    wc_byte;
    logic [WW-1:0] wc_wait;

    assign tick    = pre_q == TW'(TICK_DIV - 1);
    assign pre_d   = tick ? '0 : pre_q + 1'b1;
    assign last    = slot_q == 4'(LCD_COLS - 1);
    assign wc_rs   = is_data(state_d);
    assign wc_byte = wc_rs ? bus.char_in : cmd_byte(state_d);
    assign wc_wait = state_d == CLEAR ? WW'(CLR_WAIT_TICKS) : WW'(CMD_WAIT_TICKS);

    assign bus.index      = index_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.init_done  = init_q;
    assign bus.frame_done = frame_q;

    always_comb begin
        state_d = state_q;
        pwr_d   = pwr_q;
        slot_d  = slot_q;
        index_d = index_q;
        init_d  = init_q;
        frame_d = 1'b0;
        start   = 1'b0;
        if (state_q == PWR_WAIT) begin
            pwr_d = tick ? pwr_q + 1'b1 : pwr_q;
            start = tick && pwr_q == WW'(PWR_WAIT_TICKS - 1);
            if (start) state_d = FUNC_SET;
        end else if (done) begin
            start   = 1'b1;
            state_d = (state_q == LINE2 && last) ? ADDR1 :
                      (is_data(state_q) && !last) ? state_q : lcd_state_e'(state_q + 4'd1);
            slot_d  = (is_data(state_q) && !last) ? slot_q + 1'b1 : '0;
            init_d  = init_q || state_q == CLEAR;
            frame_d = state_q == LINE2 && last;
            // index moves only when a write is issued; line starts reload it explicitly
            index_d = state_d == ADDR1 ? 5'd0 :
                      state_d == ADDR2 ? 5'd16 :
                      is_data(state_d) ? {state_d == LINE2, slot_d} : index_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PWR_WAIT;
            pre_q   <= '0;
            pwr_q   <= '0;
            slot_q  <= '0;
            index_q <= '0;
            init_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            pwr_q   <= pwr_d;
            slot_q  <= slot_d;
            index_q <= index_d;
            init_q  <= init_d;
            frame_q <= frame_d;
        end
    end

    lcd_write_cycle #(.WW(WW)) u_wc (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .rs         (wc_rs),
        .data_byte  (wc_byte),
        .wait_ticks (wc_wait),
        .lcd_e      (bus.lcd_e),
        .lcd_rs     (bus.lcd_rs),
        .lcd_data   (bus.lcd_data),
        .done       (done)
    );
endmodule

// File: doc/lcd_text_refresh_driver.md
Name: lcd_text_refresh_driver

Overview:
- Drives an HD44780-compatible 16x2 character LCD in 8-bit write-only mode.
- Runs the power-on initialisation sequence, then refreshes both display lines continuously and forever.
- Supplies a 5-bit character index to the existing display-string character generator and receives the ASCII byte back.
- Sits between the watch/character-generator logic and the LCD pins.

Parameters:
- TICK_DIV, 50: clk cycles per timing tick (1 us at 50 MHz).
- PWR_WAIT_TICKS, 15000: ticks of idle after reset before the first command.
- CMD_WAIT_TICKS, 40: ticks of idle after each normal command or data write.
- CLR_WAIT_TICKS, 1640: ticks of idle after the clear-display command.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-low reset.
- index, output, 5: character slot requested from the character generator; 0-15 is line 1, 16-31 is line 2.
- char_in, input, 8: ASCII byte for index; valid one clk after index changes.
- lcd_rs, output, 1: 0 = command, 1 = data.
- lcd_rw, output, 1: tied 0 (write only).
- lcd_e, output, 1: enable strobe.
- lcd_data, output, 8: LCD data bus.
- init_done, output, 1: set once initialisation completes; sticky until reset.
- frame_done, output, 1: one-clk pulse after slot 31 is written.

Behaviour:
- Reset values (asynchronous, active-low): index=0, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_data=8'h00, init_done=0, frame_done=0, FSM=PWR_WAIT, all counters 0.
- Tick generation: a prescaler counts 0..TICK_DIV-1 and emits a one-clk tick at wrap. All timing below is counted in ticks.
- Reset mid-operation: asserting reset at any point aborts the transfer. lcd_e falls asynchronously, and the full init sequence restarts from PWR_WAIT.
- Write cycle (shared by every command/data byte), three phases:
  - SETUP: lcd_rs and lcd_data driven, lcd_e=0, for 1 tick.
  - STROBE: lcd_e=1 for 1 tick.
  - HOLD: lcd_e=0, lcd_rs and lcd_data held, for the wait count (CMD_WAIT_TICKS, or CLR_WAIT_TICKS after clear).
  - lcd_data and lcd_rs only change at entry to SETUP.
- FSM states in order:
  - PWR_WAIT: PWR_WAIT_TICKS.
  - FUNC_SET: 8'h38.
  - DISP_ON: 8'h0C.
  - ENTRY: 8'h06.
  - CLEAR: 8'h01, followed by the CLR_WAIT_TICKS hold.
  - At CLEAR hold end, init_done is set.
  - ADDR1: 8'h80.
  - LINE1: 16 data writes, slots 0-15.
  - ADDR2: 8'hC0.
  - LINE2: 16 data writes, slots 16-31.
  - At the end of the slot-31 hold, frame_done pulses for one clk and the FSM returns to ADDR1. There is no idle state.
- Data writes: index is updated to the slot number at the first clk of that slot's SETUP. char_in is registered into lcd_data on the second clk of SETUP, so a one-clk character generator latency is always met. The value is frozen through STROBE and HOLD.
- index is held at its last value during command states.
- index arithmetic: 5-bit, increments 0..31. It is reloaded to 0 at ADDR1 and to 16 at ADDR2, never by wrap-around.
- char_in values are passed through unchanged, with no filtering.
- Counters:
  - The wait counter is sized for max(PWR_WAIT_TICKS, CLR_WAIT_TICKS).
  - A slot counter of 4 bits counts within each line.
  - Terminal counts are compared exactly, with no overflow.

Optional Feature:
- Macro: LCD_CURSOR_BLINK_EN.
- Defined: the DISP_ON command is 8'h0F (cursor on, blink on).
- Undefined: the DISP_ON command is 8'h0C (display on, cursor off).
- No other behaviour differs.

Decomposition:
- Shared package lcd_pkg holds:
  - command constants: LCD_CMD_FUNC_SET=8'h38, LCD_CMD_DISP_ON=8'h0C, LCD_CMD_DISP_BLINK=8'h0F, LCD_CMD_ENTRY=8'h06, LCD_CMD_CLEAR=8'h01, LCD_CMD_LINE1=8'h80, LCD_CMD_LINE2=8'hC0;
  - the FSM state enumeration;
  - LCD_COLS=16.
- One sub-module: lcd_write_cycle.
  - Contains the tick-driven SETUP/STROBE/HOLD sequencer.
  - Inputs: start, rs, byte, wait_ticks.
  - Outputs: lcd_e, lcd_rs, lcd_data, done.
- The top-level module holds the sequencing FSM and the index counter.

Test Plan (TICK_DIV=2, PWR_WAIT_TICKS=10, CMD_WAIT_TICKS=3, CLR_WAIT_TICKS=6):
- Reset release:
  - Stimulus: release reset.
  - Required response: lcd_e stays 0 for 20 clks. The first strobe has lcd_rs=0 and lcd_data=8'h38, and lcd_e is high for exactly 2 clks.
- Init order:
  - Required response: strobed bytes are 38, 0C, 06, 01.
  - The gap from the 01 strobe falling edge to the next strobe rising edge is (6+1)*2 clks.
  - init_done rises at the end of the CLEAR hold.
- Full frame:
  - Stimulus: the character-generator model returns 8'h41+index with 1-clk latency.
  - Required response: the LCD model sees 80, A..P, C0, Q..`, with lcd_rs=1 on exactly the 32 data strobes.
  - frame_done pulses once per frame, and ADDR1 (8'h80) follows.
- Latency:
  - Stimulus: the model changes char_in exactly 1 clk after an index change.
  - Required response: the strobed byte matches the new index, never the old one.
- Reset mid-strobe:
  - Stimulus: assert rst while lcd_e=1 in LINE2.
  - Required response: lcd_e goes to 0 immediately. After release, the sequence restarts with PWR_WAIT then 38, and init_done is 0.
- LCD_CURSOR_BLINK_EN defined:
  - Required response: the second init byte is 8'h0F and all other bytes are unchanged.
